// File: rtl/lc3_operand_fetch.sv
// rtl/lc3_operand_fetch.sv - LC3 decode-stage operand fetch with busy-scoreboard interlock.
// Optional macro BYPASS_EN: forward same-cycle writeback data to busy sources instead of stalling.
module lc3_operand_fetch #(
    parameter int DATA_W      = 16,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            instr,
    input  logic [15:0]            npc_in,
    output logic [2:0]             sr1,
    output logic [2:0]             sr2,
    input  logic [DATA_W-1:0]      VSR1,
    input  logic [DATA_W-1:0]      VSR2,
    input  logic                   wb_en,
    input  logic [2:0]             wb_dr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_ir,
    output logic [15:0]            out_npc,
    output logic [DATA_W-1:0]      out_vsr1,
    output logic [DATA_W-1:0]      out_vsr2,
    output logic [DATA_W-1:0]      out_imm,
    output logic [2:0]             out_dr,
    output logic                   out_dr_we,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic [3:0]        opcode;
    logic [2:0]        dr;
    logic              use1, use2, dr_we;
    logic [DATA_W-1:0] imm;
    logic [7:0]        busy, busy_next;
    logic              fwd1, fwd2, hazard, accept;
    logic [DATA_W-1:0] vsr1_sel, vsr2_sel;

    assign opcode = instr[15:12];
    assign dr     = instr[11:9];
    assign sr1    = instr[8:6];
    assign sr2    = (opcode == OP_ST || opcode == OP_STI || opcode == OP_STR) ? instr[11:9] : instr[2:0];

    always_comb begin
        use1  = 1'b0;
        use2  = 1'b0;
        dr_we = 1'b0;
        imm   = '0;
        case (opcode)
            OP_ADD, OP_AND: begin
                use1  = 1'b1;
                use2  = ~instr[5];
                dr_we = 1'b1;
                if (instr[5]) imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
            end
            OP_NOT: begin
                use1  = 1'b1;
                dr_we = 1'b1;
            end
            OP_LDR: begin
                use1  = 1'b1;
                dr_we = 1'b1;
                imm   = {{(DATA_W-6){instr[5]}}, instr[5:0]};
            end
            OP_STR: begin
                use1 = 1'b1;
                use2 = 1'b1;
                imm  = {{(DATA_W-6){instr[5]}}, instr[5:0]};
            end
            OP_JMP: use1 = 1'b1;
            OP_ST, OP_STI: begin
                use2 = 1'b1;
                imm  = {{(DATA_W-9){instr[8]}}, instr[8:0]};
            end
            OP_LD, OP_LDI, OP_LEA: begin
                dr_we = 1'b1;
                imm   = {{(DATA_W-9){instr[8]}}, instr[8:0]};
            end
            OP_BR: imm = {{(DATA_W-9){instr[8]}}, instr[8:0]};
            default: ;
        endcase
    end

`ifdef BYPASS_EN
    assign fwd1 = wb_en && (wb_dr == sr1);
    assign fwd2 = wb_en && (wb_dr == sr2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign vsr1_sel = fwd1 ? wb_data : VSR1;
    assign vsr2_sel = fwd2 ? wb_data : VSR2;

    // A WAW hazard resolves as soon as the writeback retires, bypass or not.
    assign hazard = (use1 && busy[sr1] && !fwd1)
                 || (use2 && busy[sr2] && !fwd2)
                 || (dr_we && busy[dr] && !(wb_en && (wb_dr == dr)));

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        busy_next = busy;
        if (wb_en)           busy_next[wb_dr] = 1'b0;
        if (accept && dr_we) busy_next[dr]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ir    <= '0;
            out_npc   <= '0;
            out_vsr1  <= '0;
            out_vsr2  <= '0;
            out_imm   <= '0;
            out_dr    <= '0;
            out_dr_we <= 1'b0;
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_ir    <= instr;
                out_npc   <= npc_in;
                out_vsr1  <= vsr1_sel;
                out_vsr2  <= vsr2_sel;
                out_imm   <= imm;
                out_dr    <= dr;
                out_dr_we <= dr_we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            busy <= busy_next;
            if (in_valid && hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_lc3_operand_fetch.sv
// tb/tb_lc3_operand_fetch.sv - directed scoreboard bench for lc3_operand_fetch.
module tb_lc3_operand_fetch;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_en, out_valid, out_ready, out_dr_we;
    logic [15:0] instr, npc_in, vsr1_in, vsr2_in, wb_data;
    logic [15:0] out_ir, out_npc, out_vsr1, out_vsr2, out_imm;
    logic [2:0]  sr1, sr2, wb_dr, out_dr;
    logic [7:0]  stall_cnt;

    typedef struct packed {
        logic [15:0] ir, npc, vsr1, vsr2, imm;
        logic [2:0]  dr;
        logic        dr_we;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_next;
    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0] stall_base;

    always #5 clk = ~clk;

    lc3_operand_fetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .npc_in(npc_in), .sr1(sr1), .sr2(sr2),
        .VSR1(vsr1_in), .VSR2(vsr2_in), .wb_en(wb_en), .wb_dr(wb_dr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_npc(out_npc),
        .out_vsr1(out_vsr1), .out_vsr2(out_vsr2), .out_imm(out_imm), .out_dr(out_dr),
        .out_dr_we(out_dr_we), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Samples mid-cycle: pushes the expected record on accept, pops and compares on consume.
    task automatic tick();
        exp_t e;
        #2;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", 32'(out_ir), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_ir",    32'(out_ir),    32'(e.ir));
                check("sb_npc",   32'(out_npc),   32'(e.npc));
                check("sb_vsr1",  32'(out_vsr1),  32'(e.vsr1));
                check("sb_vsr2",  32'(out_vsr2),  32'(e.vsr2));
                check("sb_imm",   32'(out_imm),   32'(e.imm));
                check("sb_dr",    32'(out_dr),    32'(e.dr));
                check("sb_dr_we", 32'(out_dr_we), 32'(e.dr_we));
            end
        end
        if (in_valid && in_ready && !rst) exp_q.push_back(exp_next);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; npc_in = '0; vsr1_in = '0; vsr2_in = '0;
        wb_en = 1'b0; wb_dr = '0; wb_data = '0; out_ready = 1'b1; exp_next = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_ir",    32'(out_ir), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_busy",      32'(dut.busy), 0);
        rst = 1'b0;

        // ADD R1,R2,R3
        in_valid = 1'b1; instr = 16'h1283; npc_in = 16'h3001; vsr1_in = 16'd5; vsr2_in = 16'd7;
        exp_next = '{ir:16'h1283, npc:16'h3001, vsr1:16'd5, vsr2:16'd7, imm:16'h0, dr:3'd1, dr_we:1'b1};
        #1;
        check("add_sr1", 32'(sr1), 2);
        check("add_sr2", 32'(sr2), 3);
        check("add_in_ready", 32'(in_ready), 1);
        tick();
        check("add_out_valid", 32'(out_valid), 1);
        check("add_busy", 32'(dut.busy), 32'h02);

        // Retire R1, idle input
        in_valid = 1'b0; wb_en = 1'b1; wb_dr = 3'd1;
        tick();
        wb_en = 1'b0;
        check("wb_busy_clear", 32'(dut.busy), 0);
        check("drain_out_valid", 32'(out_valid), 0);

        // NOT R7,R0 marks R7 busy
        in_valid = 1'b1; instr = 16'h9E3F; npc_in = 16'h3002; vsr1_in = 16'h00F0; vsr2_in = 16'h0AAA;
        exp_next = '{ir:16'h9E3F, npc:16'h3002, vsr1:16'h00F0, vsr2:16'h0AAA, imm:16'h0, dr:3'd7, dr_we:1'b1};
        tick();

        // ADD R1,R1,#-1: sr2 field points at busy R7 but is unused
        instr = 16'h127F; npc_in = 16'h3003; vsr1_in = 16'd9; vsr2_in = 16'h0055;
        exp_next = '{ir:16'h127F, npc:16'h3003, vsr1:16'd9, vsr2:16'h0055, imm:16'hFFFF, dr:3'd1, dr_we:1'b1};
        #1;
        check("imm_sr2", 32'(sr2), 7);
        check("imm_in_ready", 32'(in_ready), 1);
        tick();
        check("imm_busy", 32'(dut.busy), 32'h82);

        // LD R2,#5 while R1 retires
        instr = 16'h2405; npc_in = 16'h3004; vsr1_in = 16'h0001; vsr2_in = 16'h0002;
        wb_en = 1'b1; wb_dr = 3'd1;
        exp_next = '{ir:16'h2405, npc:16'h3004, vsr1:16'h0001, vsr2:16'h0002, imm:16'h0005, dr:3'd2, dr_we:1'b1};
        tick();
        check("ld_busy", 32'(dut.busy), 32'h84);

        // ADD R4,R2,#1 with R2 retiring the same cycle
        instr = 16'h18A1; npc_in = 16'h3005; vsr1_in = 16'hDEAD; vsr2_in = 16'h0002;
        wb_en = 1'b1; wb_dr = 3'd2; wb_data = 16'h1234;
        exp_next = '{ir:16'h18A1, npc:16'h3005, vsr1:16'h1234, vsr2:16'h0002, imm:16'h0001, dr:3'd4, dr_we:1'b1};
        #1;
`ifdef BYPASS_EN
        check("raw_bypass_in_ready", 32'(in_ready), 1);
        tick();
        wb_en = 1'b0;
        stall_base = 8'd0;
`else
        check("raw_stall_in_ready", 32'(in_ready), 0);
        tick();
        wb_en = 1'b0; vsr1_in = 16'h1234;
        #1;
        check("raw_retry_in_ready", 32'(in_ready), 1);
        tick();
        stall_base = 8'd1;
`endif
        check("raw_stall_cnt", 32'(stall_cnt), 32'(stall_base));
        check("raw_busy", 32'(dut.busy), 32'h90);

        // Backpressure: STR R5,R6,#-2 waits behind a held output
        out_ready = 1'b0; instr = 16'h7BBE; npc_in = 16'h3006; vsr1_in = 16'h6666; vsr2_in = 16'h5555;
        exp_next = '{ir:16'h7BBE, npc:16'h3006, vsr1:16'h6666, vsr2:16'h5555, imm:16'hFFFE, dr:3'd5, dr_we:1'b0};
        #1;
        check("str_sr1", 32'(sr1), 6);
        check("str_sr2", 32'(sr2), 5);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_ir", 32'(out_ir), 32'h18A1);
            check("bp_out_vsr1", 32'(out_vsr1), 32'h1234);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        tick();
        check("bp_drained", 32'(out_valid), 0);

        // Fill every busy bit with LEA, then stall on a WAW
        in_valid = 1'b1; vsr1_in = '0; vsr2_in = '0;
        for (int d = 0; d < 7; d++) begin
            if (d == 4) continue;
            instr = 16'hE1FF | 16'(d << 9); npc_in = 16'h4000 + 16'(d);
            exp_next = '{ir:instr, npc:npc_in, vsr1:16'h0, vsr2:16'h0, imm:16'hFFFF, dr:3'(d), dr_we:1'b1};
            tick();
        end
        instr = 16'hE1FF; npc_in = 16'h4010;
        #1;
        check("waw_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) tick();
        check("full_busy", 32'(dut.busy), 32'hFF);
        check("waw_stall_cnt", 32'(stall_cnt), 32'(stall_base + 8'd3));

        rst = 1'b1;
        tick();
        check("mid_rst_busy", 32'(dut.busy), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_stall_cnt", 32'(stall_cnt), 0);
        rst = 1'b0; in_valid = 1'b0;
        check("sb_left_over", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
